// File: rtl/cfu_quant_sequencer.sv
// Sequences the two-stage cfu_quantizer over a stream of int32 accumulators and packs four
// int8 results per output word. Define QSEQ_SATCNT_EN to add the saturation counter.
module cfu_quant_sequencer #(
   parameter int NCH  = 16,
   parameter int CH_W = $clog2(NCH)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     cfg_we,
   input  logic [CH_W-1:0]          cfg_addr,
   input  logic signed [31:0]       cfg_bias,
   input  logic signed [31:0]       cfg_mul,
   input  logic signed [5:0]        cfg_shift,
   input  logic signed [31:0]       glb_offset,
   input  logic signed [31:0]       glb_min,
   input  logic signed [31:0]       glb_max,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [31:0]       in_acc,
   input  logic [CH_W-1:0]          in_ch,
   input  logic                     in_last,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [31:0]              out_word,
   output logic [2:0]               out_bytes,
   output logic signed [31:0]       q_data_in,
   output logic signed [31:0]       q_bias,
   output logic signed [31:0]       q_mul,
   output logic signed [31:0]       q_offset,
   output logic signed [31:0]       q_min,
   output logic signed [31:0]       q_max,
   output logic signed [5:0]        q_shift,
   output logic [1:0]               q_control,
   input  logic signed [31:0]       q_data_out,
`ifdef QSEQ_SATCNT_EN
   input  logic                     sat_clr,
   output logic [15:0]              sat_count,
`endif
   output logic                     busy
);

   localparam int DATA_W = 32;

   typedef enum logic [2:0] {IDLE, ST0, ST1, CAPT, EMIT} state_t;

   state_t state, state_nxt;

   logic signed [DATA_W-1:0] tbl_bias  [NCH];
   logic signed [DATA_W-1:0] tbl_mul   [NCH];
   logic signed [5:0]        tbl_shift [NCH];

   logic [3:0][7:0] lanes;
   logic [2:0]      cnt;
   logic            last_r;
   logic            accept;
   logic [CH_W-1:0] rd_ch;

   assign accept = in_valid & in_ready;
   // Channels past the end of a non-power-of-2 table fall back to entry 0.
   assign rd_ch  = (int'(in_ch) < NCH) ? in_ch : '0;
   assign busy   = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      q_control = 2'd3;
      out_valid = 1'b0;
      case (state)
         IDLE: begin
            in_ready = rst_n;
            if (in_valid) state_nxt = ST0;
         end
         ST0: begin
            q_control = 2'd0;
            state_nxt = ST1;
         end
         ST1: begin
            q_control = 2'd1;
            state_nxt = CAPT;
         end
         CAPT: state_nxt = (cnt == 3'd3 || last_r) ? EMIT : IDLE;
         EMIT: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign out_word  = out_valid ? lanes : '0;
   assign out_bytes = out_valid ? cnt : '0;

   // Requant table: a same-cycle accept reads the old entry since both act on one edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NCH; i++) begin
            tbl_bias[i]  <= '0;
            tbl_mul[i]   <= '0;
            tbl_shift[i] <= '0;
         end
      end else if (cfg_we && int'(cfg_addr) < NCH) begin
         tbl_bias[cfg_addr]  <= cfg_bias;
         tbl_mul[cfg_addr]   <= cfg_mul;
         tbl_shift[cfg_addr] <= cfg_shift;
      end
   end

   // Operands latch at accept and hold until the next accept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_data_in <= '0;
         q_bias    <= '0;
         q_mul     <= '0;
         q_shift   <= '0;
         q_offset  <= '0;
         q_min     <= '0;
         q_max     <= '0;
         last_r    <= 1'b0;
         lanes     <= '0;
         cnt       <= '0;
      end else begin
         if (accept) begin
            q_data_in <= in_acc;
            q_bias    <= tbl_bias[rd_ch];
            q_mul     <= tbl_mul[rd_ch];
            q_shift   <= tbl_shift[rd_ch];
            q_offset  <= glb_offset;
            q_min     <= glb_min;
            q_max     <= glb_max;
            last_r    <= in_last;
         end
         if (state == CAPT) begin
            lanes[cnt[1:0]] <= q_data_out[7:0];
            cnt             <= cnt + 3'd1;
         end
         if (state == EMIT && out_ready) begin
            lanes  <= '0;
            cnt    <= '0;
            last_r <= 1'b0;
         end
      end
   end

`ifdef QSEQ_SATCNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         sat_count <= '0;
      else if (sat_clr)
         sat_count <= '0;
      else if (state == CAPT && (q_data_out == q_min || q_data_out == q_max) &&
               sat_count != 16'hFFFF)
         sat_count <= sat_count + 16'd1;
   end
`else
   logic q_hi_unused;
   assign q_hi_unused = ^q_data_out[DATA_W-1:8];
`endif

endmodule
